// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM fader: default sizing, command
// mode encoding and the holding-register state.
package led_pwm_pkg;

   localparam int DEF_CHANNELS  = 4;
   localparam int DEF_PWM_W     = 8;
   localparam int DEF_PRESCALE  = 4;
   localparam int DEF_FADE_STEP = 1;

   localparam logic MODE_JUMP = 1'b0;
   localparam logic MODE_FADE = 1'b1;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } holdState_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: current/target brightness, period-aligned apply and fade
// stepping, and the registered PWM comparator.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_W     = DEF_PWM_W,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   input  logic             period_end_i,
   input  logic             apply_en_i,
   input  logic [PWM_W-1:0] level_i,
   input  logic             fade_i,
   output logic             led_o,
   output logic             fading_o
);

   localparam logic [PWM_W:0] STEP = (PWM_W + 1)'(FADE_STEP);

   logic [PWM_W-1:0] cur_q, cur_d;
   logic [PWM_W-1:0] tgt_q, tgt_d;
   logic             led_q, fading_q;
   logic [PWM_W:0]   curWide, tgtWide, upSum, downLimit, stepped;

   // The extra bit keeps cur+STEP and tgt+STEP from wrapping, so the clamp
   // compares are exact even near full scale.
   always_comb begin
      curWide   = {1'b0, cur_q};
      tgtWide   = {1'b0, tgt_q};
      upSum     = curWide + STEP;
      downLimit = tgtWide + STEP;
      stepped   = curWide;
      if (cur_q < tgt_q) begin
         stepped = (upSum > tgtWide) ? tgtWide : upSum;
      end else if (cur_q > tgt_q) begin
         stepped = (curWide < downLimit) ? tgtWide : (curWide - STEP);
      end
   end

   // A command landing on this channel takes priority over the fade step.
   always_comb begin
      cur_d = cur_q;
      tgt_d = tgt_q;
      if (period_end_i) begin
         if (apply_en_i) begin
            tgt_d = level_i;
            if (fade_i == MODE_JUMP) begin
               cur_d = level_i;
            end
         end else begin
            cur_d = PWM_W'(stepped);
         end
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         cur_q    <= '0;
         tgt_q    <= '0;
         led_q    <= 1'b0;
         fading_q <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         led_q    <= (pwm_cnt_i < cur_q);
         fading_q <= (cur_q != tgt_q);
      end
   end

   assign led_o    = led_q;
   assign fading_o = fading_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED fader top: prescaler, shared PWM counter, single-entry command holding
// register with valid/ready handshake, and one led_pwm_channel per LED.
module led_pwm_fader
   import led_pwm_pkg::*;
#(
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int PWM_W     = DEF_PWM_W,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int FADE_STEP = DEF_FADE_STEP
) (
   input  logic                                            clock,
   input  logic                                            rstn,
   input  logic                                            cfg_valid,
   output logic                                            cfg_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
   input  logic [PWM_W-1:0]                                cfg_level,
   input  logic                                            cfg_fade,
   output logic [CHANNELS-1:0]                             led_out,
   output logic [CHANNELS-1:0]                             fading
);

   localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [PWM_W-1:0] CNT_LAST = '1;

   logic [PS_W-1:0]   presc_q, presc_d;
   logic [PWM_W-1:0]  pwmCnt_q, pwmCnt_d;
   holdState_e        hold_q, hold_d;
   logic [CHAN_W-1:0] holdChan_q, holdChan_d;
   logic [PWM_W-1:0]  holdLevel_q, holdLevel_d;
   logic              holdFade_q, holdFade_d;
   logic              tick, periodEnd, applyNow;

   // With PRESCALE=1 the prescaler sits at 0 and every cycle is a tick.
   always_comb begin
      tick      = (presc_q == PS_LAST);
      periodEnd = tick && (pwmCnt_q == CNT_LAST);
      presc_d   = tick ? '0 : (presc_q + 1'b1);
      pwmCnt_d  = tick ? (pwmCnt_q + 1'b1) : pwmCnt_q;
   end

   // Commands wait in the holding register until a period boundary so that
   // a duty change never lands mid-period.
   always_comb begin
      hold_d      = hold_q;
      holdChan_d  = holdChan_q;
      holdLevel_d = holdLevel_q;
      holdFade_d  = holdFade_q;
      applyNow    = 1'b0;
      case (hold_q)
         HOLD_EMPTY: begin
            if (cfg_valid) begin
               hold_d      = HOLD_FULL;
               holdChan_d  = cfg_chan;
               holdLevel_d = cfg_level;
               holdFade_d  = cfg_fade;
            end
         end
         HOLD_FULL: begin
            if (periodEnd) begin
               applyNow = 1'b1;
               hold_d   = HOLD_EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         presc_q     <= '0;
         pwmCnt_q    <= '0;
         hold_q      <= HOLD_EMPTY;
         holdChan_q  <= '0;
         holdLevel_q <= '0;
         holdFade_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         pwmCnt_q    <= pwmCnt_d;
         hold_q      <= hold_d;
         holdChan_q  <= holdChan_d;
         holdLevel_q <= holdLevel_d;
         holdFade_q  <= holdFade_d;
      end
   end

   assign cfg_ready = (hold_q == HOLD_EMPTY);

   // An out-of-range channel matches no instance, so it is consumed silently.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      led_pwm_channel #(
         .PWM_W     (PWM_W),
         .FADE_STEP (FADE_STEP)
      ) u_chan (
         .clock        (clock),
         .rstn         (rstn),
         .pwm_cnt_i    (pwmCnt_q),
         .period_end_i (periodEnd),
         .apply_en_i   (applyNow && (int'(holdChan_q) == i)),
         .level_i      (holdLevel_q),
         .fade_i       (holdFade_q),
         .led_o        (led_out[i]),
         .fading_o     (fading[i])
      );
   end

endmodule
